// File: rtl/buff_pkg.sv
// buff_pkg: definitions shared by the buffer blocks.
//   OVWR_DROP / OVWR_OLDEST : encodings for the full-write handling mode.
//   ptr_inc                 : pointer increment that wraps at an arbitrary depth,
//                             so depths that are not powers of two work.
package buff_pkg;

    localparam int OVWR_DROP   = 0;
    localparam int OVWR_OLDEST = 1;

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage for ring_fifo.
//   CLK, RST : clock; synchronous active-high reset (clears only the read register)
//   wr_en, wr_addr, wr_data : write port, data stored on the clock edge
//   rd_en, rd_addr          : read request; rd_data updates one cycle later
//   rd_data                 : registered read data, holds when rd_en is low
// The storage array itself is never reset.
module fifo_mem #(
    parameter int  DATAWIDTH = 8,
    parameter int  DEPTH     = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stage p1: registered read port. A read and a write to the same address in
    // one cycle return the old contents, which is what a full FIFO needs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ring_fifo.sv
// ring_fifo: synchronous ring-buffer FIFO with occupancy flags.
//   CLK, RST    : clock; synchronous active-high reset (wins over READ/WRITE)
//   WRITE/WRDATA: write request and data
//   READ        : read request; RDDATA/RDVALID follow one cycle later
//   ISFULL, ISEMPTY, ALMOSTFULL, ALMOSTEMPTY : decodes of COUNT
//   COUNT       : current occupancy
//   OVERFLOW    : pulse on a write that hit a full FIFO without a read
//   UNDERFLOW   : pulse on a read of an empty FIFO
module ring_fifo
    import buff_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int PTRSIZE   = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int OVWR_MODE = OVWR_DROP
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WRITE,
    input  logic [DATAWIDTH-1:0] WRDATA,
    input  logic                 READ,
    output logic [DATAWIDTH-1:0] RDDATA,
    output logic                 RDVALID,
    output logic                 ISFULL,
    output logic                 ISEMPTY,
    output logic                 ALMOSTFULL,
    output logic                 ALMOSTEMPTY,
    output logic [PTRSIZE:0]     COUNT,
    output logic                 OVERFLOW,
    output logic                 UNDERFLOW
);

    localparam logic [PTRSIZE:0] DEPTH_C  = (PTRSIZE + 1)'(DEPTH);
    localparam logic [PTRSIZE:0] AFULL_C  = (PTRSIZE + 1)'(AFULL_TH);
    localparam logic [PTRSIZE:0] AEMPTY_C = (PTRSIZE + 1)'(AEMPTY_TH);
    localparam logic [PTRSIZE:0] CNT_ONE  = (PTRSIZE + 1)'(1);
    localparam logic             OVWR_EN  = (OVWR_MODE == OVWR_OLDEST);

    logic [PTRSIZE-1:0] wr_ptr, rd_ptr;
    logic [PTRSIZE-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [PTRSIZE:0]   count;

    logic full_p0, empty_p0;
    logic rd_ok_p0, wr_ok_p0, ovwr_p0, drop_p0;

    // Stage p0: accept decisions from the registered count and this cycle's requests.
    always_comb begin
        full_p0    = (count == DEPTH_C);
        empty_p0   = (count == '0);
        rd_ok_p0   = READ && !empty_p0;
        // A full FIFO still takes a write when a read frees a slot in the same cycle.
        wr_ok_p0   = WRITE && (!full_p0 || rd_ok_p0 || OVWR_EN);
        ovwr_p0    = WRITE && full_p0 && !READ && OVWR_EN;
        drop_p0    = WRITE && full_p0 && !READ && !OVWR_EN;
        wr_ptr_nxt = PTRSIZE'(ptr_inc(int'(wr_ptr), DEPTH));
        rd_ptr_nxt = PTRSIZE'(ptr_inc(int'(rd_ptr), DEPTH));
    end

    // Stage p1: pointer, count and pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            RDVALID   <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wr_ok_p0) begin
                wr_ptr <= wr_ptr_nxt;
            end
            // Overwriting the oldest entry also retires it, so the read side moves too.
            if (rd_ok_p0 || ovwr_p0) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({wr_ok_p0 && !ovwr_p0, rd_ok_p0})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            RDVALID   <= rd_ok_p0;
            OVERFLOW  <= ovwr_p0 || drop_p0;
            UNDERFLOW <= READ && empty_p0;
        end
    end

    fifo_mem #(
        .DATAWIDTH(DATAWIDTH),
        .DEPTH    (DEPTH)
    ) u_mem (
        .CLK    (CLK),
        .RST    (RST),
        .wr_en  (wr_ok_p0 && !RST),
        .wr_addr(wr_ptr),
        .wr_data(WRDATA),
        .rd_en  (rd_ok_p0 && !RST),
        .rd_addr(rd_ptr),
        .rd_data(RDDATA)
    );

    assign COUNT       = count;
    assign ISFULL      = (count == DEPTH_C);
    assign ISEMPTY     = (count == '0);
    assign ALMOSTFULL  = (count >= AFULL_C);
    assign ALMOSTEMPTY = (count <= AEMPTY_C);

endmodule

// File: tb/tb_ring_fifo.sv
// tb_ring_fifo: drives three ring_fifo instances with the same stimulus
// (DEPTH 8 drop mode, DEPTH 8 overwrite mode, DEPTH 5 drop mode) and checks
// each against a queue model, a read-data scoreboard and hand-written values.
module tb_ring_fifo;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst, wr, rd;
    logic [7:0] wd;

    logic [7:0] rdd  [3];
    logic       rdv  [3];
    logic       full [3];
    logic       empty[3];
    logic       af   [3];
    logic       ae   [3];
    logic       ovf  [3];
    logic       unf  [3];
    logic [3:0] cnt  [3];

    ring_fifo #(.DATAWIDTH(8), .DEPTH(8), .OVWR_MODE(0)) u_d8 (
        .CLK(CLK), .RST(rst), .WRITE(wr), .WRDATA(wd), .READ(rd),
        .RDDATA(rdd[0]), .RDVALID(rdv[0]), .ISFULL(full[0]), .ISEMPTY(empty[0]),
        .ALMOSTFULL(af[0]), .ALMOSTEMPTY(ae[0]), .COUNT(cnt[0]),
        .OVERFLOW(ovf[0]), .UNDERFLOW(unf[0]));

    ring_fifo #(.DATAWIDTH(8), .DEPTH(8), .OVWR_MODE(1)) u_o8 (
        .CLK(CLK), .RST(rst), .WRITE(wr), .WRDATA(wd), .READ(rd),
        .RDDATA(rdd[1]), .RDVALID(rdv[1]), .ISFULL(full[1]), .ISEMPTY(empty[1]),
        .ALMOSTFULL(af[1]), .ALMOSTEMPTY(ae[1]), .COUNT(cnt[1]),
        .OVERFLOW(ovf[1]), .UNDERFLOW(unf[1]));

    ring_fifo #(.DATAWIDTH(8), .DEPTH(5), .OVWR_MODE(0)) u_d5 (
        .CLK(CLK), .RST(rst), .WRITE(wr), .WRDATA(wd), .READ(rd),
        .RDDATA(rdd[2]), .RDVALID(rdv[2]), .ISFULL(full[2]), .ISEMPTY(empty[2]),
        .ALMOSTFULL(af[2]), .ALMOSTEMPTY(ae[2]), .COUNT(cnt[2]),
        .OVERFLOW(ovf[2]), .UNDERFLOW(unf[2]));

    int checks   = 0;
    int failures = 0;

    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] sb0[$], sb1[$], sb2[$];
    logic [7:0] last_rd[3];
    bit         e_v[3], e_ovf[3], e_unf[3];
    int         depth_of[3] = '{8, 8, 5};
    bit         ovwr_of[3]  = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        bit         rst, wr, rd;
        logic [7:0] d;
        int         cnt;
        bit         full, afull, empty, rdv;
        logic [7:0] rdd;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h expected=%0h", nm, k, act, exp);
        end
    endtask

    // Advance the reference queue of instance k for the inputs about to be clocked.
    task automatic model_step(input int k);
        logic [7:0] q[$];
        logic [7:0] sb[$];
        bit full_s, rok;
        case (k)
            0: begin q = q0; sb = sb0; end
            1: begin q = q1; sb = sb1; end
            default: begin q = q2; sb = sb2; end
        endcase
        e_v[k] = 1'b0; e_ovf[k] = 1'b0; e_unf[k] = 1'b0;
        if (rst) begin
            q.delete();
            sb.delete();
            last_rd[k] = 8'h00;
        end else begin
            full_s = (q.size() == depth_of[k]);
            rok    = rd && (q.size() != 0);
            if (rd && q.size() == 0) e_unf[k] = 1'b1;
            if (rok) begin
                sb.push_back(q.pop_front());
                e_v[k] = 1'b1;
            end
            if (wr) begin
                if (!full_s || rok) begin
                    q.push_back(wd);
                end else begin
                    e_ovf[k] = 1'b1;
                    if (ovwr_of[k]) begin
                        q.delete(0);
                        q.push_back(wd);
                    end
                end
            end
        end
        case (k)
            0: begin q0 = q; sb0 = sb; end
            1: begin q1 = q; sb1 = sb; end
            default: begin q2 = q; sb2 = sb; end
        endcase
    endtask

    task automatic check_dut(input int k);
        logic [7:0] q[$];
        logic [7:0] sb[$];
        int n, dep;
        case (k)
            0: begin q = q0; sb = sb0; end
            1: begin q = q1; sb = sb1; end
            default: begin q = q2; sb = sb2; end
        endcase
        n   = q.size();
        dep = depth_of[k];
        chk("count",       k, int'(cnt[k]),   n);
        chk("isfull",      k, int'(full[k]),  int'(n == dep));
        chk("isempty",     k, int'(empty[k]), int'(n == 0));
        chk("almostfull",  k, int'(af[k]),    int'(n >= dep - 2));
        chk("almostempty", k, int'(ae[k]),    int'(n <= 2));
        chk("overflow",    k, int'(ovf[k]),   int'(e_ovf[k]));
        chk("underflow",   k, int'(unf[k]),   int'(e_unf[k]));
        chk("rdvalid",     k, int'(rdv[k]),   int'(e_v[k]));
        if (rdv[k] === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard dut%0d got=RDVALID expected=no pending read", k);
            end else begin
                last_rd[k] = sb.pop_front();
            end
        end
        chk("rddata", k, int'(rdd[k]), int'(last_rd[k]));
        case (k)
            0: sb0 = sb;
            1: sb1 = sb;
            default: sb2 = sb;
        endcase
    endtask

    task automatic cyc(input bit r_s, input bit w, input bit r, input logic [7:0] d);
        rst = r_s; wr = w; rd = r; wd = d;
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; wd = 8'h00;
        for (int k = 0; k < 3; k++) last_rd[k] = 8'h00;

        // Fill/drain table for the DEPTH=8 instance.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b0, 8'(i + 1), i + 1, (i == 7), (i + 1 >= 6),
                       1'b0, 1'b0, 8'h00};
        for (int j = 0; j < 8; j++)
            tbl[8 + j] = '{1'b0, 1'b0, 1'b1, 8'h00, 7 - j, 1'b0, (7 - j >= 6),
                           (j == 7), 1'b1, 8'(j + 1)};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08};

        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("reset_empty", 0, int'(empty[0]), 1);
        chk("reset_ae",    0, int'(ae[0]),    1);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk("tbl_count", 0, int'(cnt[0]),   tbl[i].cnt);
            chk("tbl_full",  0, int'(full[0]),  int'(tbl[i].full));
            chk("tbl_afull", 0, int'(af[0]),    int'(tbl[i].afull));
            chk("tbl_empty", 0, int'(empty[0]), int'(tbl[i].empty));
            chk("tbl_rdv",   0, int'(rdv[0]),   int'(tbl[i].rdv));
            chk("tbl_rdd",   0, int'(rdd[0]),   int'(tbl[i].rdd));
        end

        // Read on empty, then read+write on empty.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("empty_rd_unf", 0, int'(unf[0]), 1);
        chk("empty_rd_rdv", 0, int'(rdv[0]), 0);
        cyc(1'b0, 1'b1, 1'b1, 8'hAA);
        chk("empty_rw_cnt", 0, int'(cnt[0]), 1);
        chk("empty_rw_unf", 0, int'(unf[0]), 1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("empty_rw_rdd", 0, int'(rdd[0]), 8'hAA);

        // Full with 0x01..0x08, then a write-only of 0x99, then drain.
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
        cyc(1'b0, 1'b1, 1'b0, 8'h99);
        chk("full_ovf_drop", 0, int'(ovf[0]), 1);
        chk("full_ovf_ovwr", 1, int'(ovf[1]), 1);
        chk("full_cnt_ovwr", 1, int'(cnt[1]), 8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_drop", 0, int'(rdd[0]), i + 1);
            chk("drain_ovwr", 1, int'(rdd[1]), (i < 7) ? i + 2 : 8'h99);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Read+write while full is accepted on both sides.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        cyc(1'b0, 1'b1, 1'b1, 8'h55);
        chk("full_rw_ovf", 0, int'(ovf[0]), 0);
        chk("full_rw_cnt", 0, int'(cnt[0]), 8);
        chk("full_rw_rdd", 0, int'(rdd[0]), 8'h21);

        // Streaming across the DEPTH=5 pointer wrap at occupancy 3.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'(8'h40 + i));
            chk("wrap_cnt", 2, int'(cnt[2]), 3);
            chk("wrap_rdd", 2, int'(rdd[2]), (i < 3) ? 8'h30 + i : 8'h40 + i - 3);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset with a read pending at occupancy 4.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rst_mid_cnt",   0, int'(cnt[0]),   0);
        chk("rst_mid_rdv",   0, int'(rdv[0]),   0);
        chk("rst_mid_empty", 0, int'(empty[0]), 1);
        chk("rst_mid_rdd",   0, int'(rdd[0]),   0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("rst_mid_unf",   0, int'(unf[0]),   1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_fifo.md
RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 Parameter DATAWIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the entry count; any value >= 2 is legal, not only powers of two.
REQ-003 Parameter PTRSIZE, default $clog2(DEPTH), SHALL set the pointer width.
REQ-004 Parameter AFULL_TH, default DEPTH-2, SHALL set the almost-full threshold.
REQ-005 Parameter AEMPTY_TH, default 2, SHALL set the almost-empty threshold.
REQ-006 Parameter OVWR_MODE, default 0, SHALL select full-write handling: 0 drops the write, 1 overwrites the oldest entry.
REQ-007 Ports, clock and reset first:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- WRITE  in  1  write request.
- WRDATA  in  DATAWIDTH  write data.
- READ  in  1  read request.
- RDDATA  out  DATAWIDTH  registered read data.
- RDVALID  out  1  RDDATA valid, one-cycle pulse.
- ISFULL  out  1  count == DEPTH.
- ISEMPTY  out  1  count == 0.
- ALMOSTFULL  out  1  count >= AFULL_TH.
- ALMOSTEMPTY  out  1  count <= AEMPTY_TH.
- COUNT  out  PTRSIZE+1  current occupancy.
- OVERFLOW  out  1  one-cycle pulse on a dropped or overwriting write.
- UNDERFLOW  out  1  one-cycle pulse on a rejected read.

Function
REQ-008 An accepted write SHALL store WRDATA at wrptr in the same clock edge, so the data is readable from the next cycle.
REQ-009 An accepted read SHALL drive RDDATA from rdptr with RDVALID=1 on the following cycle (read latency 1).
REQ-010 When no read is accepted, RDDATA SHALL hold its last value and RDVALID SHALL be 0.
REQ-011 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-012 COUNT SHALL:
- increase by 1 on write-only accept;
- decrease by 1 on read-only accept;
- stay unchanged when a read and a write are both accepted.
REQ-013 Read when empty, with or without WRITE, SHALL be rejected: UNDERFLOW=1, rdptr unchanged. A simultaneous write SHALL still be accepted (COUNT 0->1).
REQ-014 READ and WRITE when full SHALL both be accepted: COUNT stays DEPTH, OVERFLOW=0.
REQ-015 Write-only when full with OVWR_MODE=0 SHALL be dropped: memory and wrptr unchanged, OVERFLOW=1.
REQ-016 Write-only when full with OVWR_MODE=1 SHALL:
- write at wrptr and advance both pointers;
- hold COUNT at DEPTH;
- pulse OVERFLOW=1;
- leave RDVALID=0.
REQ-017 ISFULL, ISEMPTY, ALMOSTFULL and ALMOSTEMPTY SHALL be combinational decodes of the registered COUNT.
REQ-018 Status outputs SHALL never be simultaneously asserted in contradiction: ISFULL and ISEMPTY are never both 1.

Reset
REQ-019 RST SHALL take priority over READ and WRITE in the same cycle.
REQ-020 RST SHALL clear wrptr, rdptr, COUNT, RDVALID, OVERFLOW, UNDERFLOW and RDDATA to 0, giving ISEMPTY=1, ALMOSTEMPTY=1, ISFULL=0 and ALMOSTFULL=0 after reset.
REQ-021 Memory contents SHALL NOT be reset.
REQ-022 Reset mid-operation SHALL discard all stored entries; a RDVALID pulse pending from the prior cycle SHALL be suppressed.

Structure
REQ-023 A shared package buff_pkg SHALL hold the OVWR_MODE encodings (OVWR_DROP=0, OVWR_OLDEST=1) and a pointer-increment-with-wrap function used by all buffer blocks.
REQ-024 Storage SHALL be a single sub-module fifo_mem with these properties:
- simple dual-port, one write port and one registered read port;
- parameters DATAWIDTH and DEPTH;
- pointer, count and flag control kept in ring_fifo.

Verification
REQ-025 Fill test (DEPTH=8, DATAWIDTH=8): write 0x01..0x08 -> ALMOSTFULL asserts at COUNT=6, ISFULL=1 at COUNT=8; then read 8 -> RDDATA 0x01..0x08, each one cycle after READ, ending with ISEMPTY=1.
REQ-026 Empty-read test: READ on empty -> UNDERFLOW pulse, RDVALID=0, COUNT=0. READ+WRITE 0xAA on empty -> COUNT=1, UNDERFLOW=1; next read returns 0xAA.
REQ-027 Full, mode 0: full with 0x01..0x08, write 0x99 -> OVERFLOW pulse, COUNT=8; drain returns 0x01..0x08.
REQ-028 Full, mode 1: same fill, write 0x99 -> OVERFLOW pulse, COUNT=8; drain returns 0x02..0x08, 0x99.
REQ-029 Wrap with DEPTH=5: 12 streaming cycles of simultaneous READ+WRITE at COUNT=3 -> COUNT stays 3, data order preserved across pointer wrap 4->0.
REQ-030 Reset mid-stream: RST asserted with READ=1 at COUNT=4 -> next cycle COUNT=0, RDVALID=0, ISEMPTY=1.
